// File: rtl/rr_mux_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_buf
//  Description : N-input, W-bit arbitrating multiplexer with a one-entry
//                registered output buffer. Channels are chosen round-robin
//                (mode=0) or by a fixed index (mode=1); the winning word is
//                held in the buffer until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_buf #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        fix_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Number of addressable channel slots for a SEL_W-bit index; channels at or
  // above NUM_IN read as permanently idle.
  localparam int                 c_NPAD    = 1 << SEL_W;
  localparam logic [SEL_W:0]     c_NUM_EXT = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0]   c_LAST    = SEL_W'(NUM_IN - 1);

  // --------------------------------------------------------------------------
  // State: output buffer and round-robin priority pointer
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] chan_q,  chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  // --------------------------------------------------------------------------
  // Arbitration signals
  // --------------------------------------------------------------------------
  logic [c_NPAD-1:0] w_valid_pad;
  logic              w_rr_found;
  logic [SEL_W-1:0]  w_rr_win;
  logic              w_has_win;
  logic [SEL_W-1:0]  w_win;
  logic              w_free;
  logic              w_accept;
  logic [SEL_W-1:0]  w_ptr_inc;
  logic [WIDTH-1:0]  w_mux_data;

  // Widen in_valid so that any SEL_W-bit index (including out-of-range
  // fixed selects) can be looked up safely; missing channels read as 0.
  always_comb begin
    w_valid_pad               = '0;
    w_valid_pad[NUM_IN-1:0]   = in_valid;
  end

  // Round-robin scan: first valid channel starting at ptr_q, wrapping mod NUM_IN.
  always_comb begin
    logic [SEL_W:0] sum;
    w_rr_found = 1'b0;
    w_rr_win   = '0;
    sum        = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      sum = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (sum >= c_NUM_EXT) begin
        sum = sum - c_NUM_EXT;
      end
      if (!w_rr_found && w_valid_pad[sum[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_win   = sum[SEL_W-1:0];
      end
    end
  end

  // Winner selection for the current mode; a fixed select only wins when the
  // named channel exists and is presenting a word.
  always_comb begin
    if (mode) begin
      w_has_win = w_valid_pad[fix_sel];
      w_win     = fix_sel;
    end else begin
      w_has_win = w_rr_found;
      w_win     = w_rr_win;
    end
  end

  // The buffer can take a word when it is empty or being drained this cycle.
  assign w_free    = !valid_q | out_ready;
  assign w_accept  = w_free & !rst & w_has_win;
  assign w_ptr_inc = (w_win == c_LAST) ? '0 : w_win + 1'b1;

  // One-hot grant back to the producers; only the winner sees ready.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_grant
    localparam logic [SEL_W-1:0] c_IDX = SEL_W'(gi);
    assign in_ready[gi] = w_accept & (w_win == c_IDX);
  end

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (in_ready[i]) begin
        w_mux_data = w_mux_data | in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state: load on accept, empty on drain-only, otherwise hold.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (w_accept) begin
      data_d  = w_mux_data;
      chan_d  = w_win;
      valid_d = 1'b1;
      if (!mode) begin
        ptr_d = w_ptr_inc;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a buffered word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_buf
//  Description : Self-checking bench for rr_mux_buf: directed scenarios with
//                literal expectations plus randomized traffic compared every
//                cycle against a queue/arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_buf;

  localparam int NUM = 4;
  localparam int WID = 16;

  logic              clk;
  logic              rst;
  logic [NUM*WID-1:0] in_data;
  logic [NUM-1:0]    in_valid;
  logic [NUM-1:0]    in_ready;
  logic              mode;
  logic [1:0]        fix_sel;
  logic [WID-1:0]    out_data;
  logic [1:0]        out_chan;
  logic              out_valid;
  logic              out_ready;

  // Three-channel instance for the out-of-range fixed select case
  logic              rst3;
  logic [3*WID-1:0]  in_data3;
  logic [2:0]        in_valid3;
  logic [2:0]        in_ready3;
  logic              mode3;
  logic [1:0]        fix_sel3;
  logic [WID-1:0]    out_data3;
  logic [1:0]        out_chan3;
  logic              out_valid3;
  logic              out_ready3;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  rr_mux_buf #(.WIDTH(WID), .NUM_IN(NUM), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .fix_sel(fix_sel),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_buf #(.WIDTH(WID), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .fix_sel(fix_sel3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic           m_valid;
  logic [WID-1:0] m_data;
  int             m_chan;
  int             m_ptr;
  int             m_acc;   // channel accepted at the last edge, -1 if none

  // Winner per the arbitration rules, -1 when nobody is eligible.
  function automatic int model_winner();
    if (mode) begin
      if (int'(fix_sel) < NUM && in_valid[fix_sel]) return int'(fix_sel);
      return -1;
    end
    for (int k = 0; k < NUM; k++) begin
      int c;
      c = (m_ptr + k) % NUM;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NUM-1:0] model_ready();
    int w;
    w = model_winner();
    if (rst || (m_valid && !out_ready) || w < 0) return '0;
    return NUM'(1 << w);
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= 0;
      m_ptr   <= 0;
      m_acc   <= -1;
    end else begin
      w = model_winner();
      if ((!m_valid || out_ready) && w >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[w*WID +: WID];
        m_chan  <= w;
        if (!mode) m_ptr <= (w + 1) % NUM;
        m_acc   <= w;
      end else begin
        if (out_ready) m_valid <= 1'b0;
        m_acc <= -1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready",  32'(in_ready),  32'(model_ready()));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data",  32'(out_data),  32'(m_data));
      chk("m_out_chan",  32'(out_chan),  32'(m_chan));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data_a0();
    for (int i = 0; i < NUM; i++) in_data[i*WID +: WID] = 16'h00A0 + 16'(i);
  endtask

  logic [NUM-1:0] pv;

  initial begin
    rst = 1'b1; in_valid = 4'b1111; mode = 1'b0; fix_sel = 2'd0; out_ready = 1'b1;
    in_data = '0; set_data_a0();
    rst3 = 1'b1; in_valid3 = 3'b000; mode3 = 1'b0; fix_sel3 = 2'd0; out_ready3 = 1'b1;
    in_data3 = {16'h00C2, 16'h00C1, 16'h00C0};

    // Reset held for two edges with all channels valid
    tick(); cmp_en = 1;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      if (r == 0) tick();
    end
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("first_grant", 32'(in_ready), 32'b0001);

    // Round-robin order A0 A1 A2 A3 A0, then backpressure on the last A0
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) out_ready = 1'b0;
      @(negedge clk);
      chk("rr_data", 32'(out_data), 32'h00A0 + 32'(i % 4));
      chk("rr_chan", 32'(out_chan), 32'(i % 4));
    end
    chk("bp_ready0", 32'(in_ready), 32'h0);
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("bp_data",  32'(out_data), 32'h00A0);
      chk("bp_ready", 32'(in_ready), 32'h0);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    tick();
    @(negedge clk);
    chk("bp_release_data", 32'(out_data), 32'h00A1);
    chk("rr_ch2_next", 32'(in_ready), 32'b0100);

    // Wrap and skip: ch2 wins (ptr->3), then only ch1 valid
    tick(); in_valid = 4'b0010;
    @(negedge clk);
    chk("skip_out_chan2", 32'(out_chan), 32'd2);
    chk("skip_ready",     32'(in_ready), 32'b0010);
    tick(); in_valid = 4'b1111;
    @(negedge clk);
    chk("skip_chan", 32'(out_chan), 32'd1);
    chk("skip_ptr2", 32'(in_ready), 32'b0100);

    // Fixed mode on channel 2
    tick(); mode = 1'b1; fix_sel = 2'd2;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("fix_ready", 32'(in_ready), 32'b0100);
      tick();
      @(negedge clk);
      chk("fix_chan", 32'(out_chan), 32'd2);
    end

    // Reset while a word is stalled in the buffer
    out_ready = 1'b0; mode = 1'b0;
    @(negedge clk);
    chk("mid_valid_before", 32'(out_valid), 32'h1);
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("mid_valid_after", 32'(out_valid), 32'h0);
    chk("mid_grant_ch0",   32'(in_ready),  32'b0001);

    // Randomized traffic obeying the producer hold rule
    pv = in_valid;
    out_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int c = 0; c < NUM; c++) begin
        if (pv[c] && m_acc == c) pv[c] = 1'b0;
        if (rst) pv[c] = 1'b0;
        if (!pv[c] && $urandom_range(0, 99) < 55) begin
          pv[c] = 1'b1;
          in_data[c*WID +: WID] = 16'($urandom);
        end
      end
      in_valid  = pv;
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) mode = ~mode;
      if ($urandom_range(0, 99) < 10) fix_sel = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
    end
    tick(); rst = 1'b0;

    // Three-channel instance: fixed select beyond the last channel
    rst3 = 1'b0; in_valid3 = 3'b111;
    @(negedge clk);
    chk("n3_grant0", 32'(in_ready3), 32'b001);
    tick(); mode3 = 1'b1; fix_sel3 = 2'd3;
    @(negedge clk);
    chk("n3_valid",     32'(out_valid3), 32'h1);
    chk("n3_data",      32'(out_data3),  32'h00C0);
    chk("n3_ready_oob", 32'(in_ready3),  32'b000);
    tick();
    @(negedge clk);
    chk("n3_drained",    32'(out_valid3), 32'h0);
    chk("n3_ready_oob2", 32'(in_ready3),  32'b000);
    tick();
    @(negedge clk);
    chk("n3_still_empty", 32'(out_valid3), 32'h0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
